// File: rtl/qpsk_pkg.sv
// Shared types and constants for the QPSK symbol sequencer slice.
package qpsk_pkg;

  localparam int unsigned NIB_W          = 4;
  localparam int unsigned SYM_CYCLES_DEF = 52;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_e;

  typedef struct packed {
    logic [NIB_W-1:0] even;
    logic [NIB_W-1:0] odd;
  } nibble_pair_t;

endpackage

// File: rtl/qpsk_symbol_sequencer_if.sv
// Nibble-pair input handshake plus serialized I/Q symbol outputs.
interface qpsk_symbol_sequencer_if;
  import qpsk_pkg::*;

  logic             run_en;
  logic [NIB_W-1:0] in_even;
  logic [NIB_W-1:0] in_odd;
  logic             in_valid;
  logic             in_ready;
  logic             even;
  logic             odd;
  logic             sym_strobe;
  logic             busy;
  logic             underflow;

  modport master (
    output run_en, in_even, in_odd, in_valid,
    input  in_ready, even, odd, sym_strobe, busy, underflow
  );

  modport slave (
    input  run_en, in_even, in_odd, in_valid,
    output in_ready, even, odd, sym_strobe, busy, underflow
  );

endinterface

// File: rtl/qpsk_symbol_timer.sv
// Symbol cycle counter and bit index within the current nibble word.
module qpsk_symbol_timer
  import qpsk_pkg::*;
#(
  parameter int unsigned SYM_CYCLES = SYM_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       clr,
  output logic [1:0] idx,
  output logic       bit_end,
  output logic       word_end
);

  localparam int unsigned     CNT_W    = (SYM_CYCLES > 1) ? $clog2(SYM_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SYM_CYCLES - 1);

  logic [CNT_W-1:0] cnt;

  assign bit_end  = en && (cnt == CNT_LAST);
  assign word_end = bit_end && (idx == 2'd3);

  // Counters hold while disabled so a paused bit resumes where it stopped.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (clr) begin
      cnt <= '0;
      idx <= 2'd0;
    end else if (en) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
        idx <= 2'(idx + 2'd1);
      end else begin
        cnt <= CNT_W'(cnt + 1'b1);
      end
    end
  end

endmodule

// File: rtl/qpsk_symbol_sequencer.sv
// Buffers even/odd nibble pairs and emits one I/Q bit pair per symbol period, LSB first.
module qpsk_symbol_sequencer
  import qpsk_pkg::*;
#(
  parameter int unsigned SYM_CYCLES = SYM_CYCLES_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  qpsk_symbol_sequencer_if.slave  bus
);

  state_e       state;
  nibble_pair_t cur;
  nibble_pair_t pend;
  nibble_pair_t in_pair;
  logic         pend_v;
  logic         uf_pend;
  logic         sym_first;
  logic         even_q;
  logic         odd_q;
  logic         strobe_q;
  logic         underflow_q;
  logic [1:0]   idx;
  logic         bit_end;
  logic         word_end;
  logic         tmr_en;
  logic         tmr_clr;
  logic         xfer;

  assign in_pair.even = bus.in_even;
  assign in_pair.odd  = bus.in_odd;
  assign xfer         = bus.in_valid && !pend_v;
  assign tmr_en       = (state == RUN) && bus.run_en;
  assign tmr_clr      = (state == IDLE);

  assign bus.in_ready   = !pend_v;
  assign bus.busy       = (state == RUN);
  assign bus.even       = even_q;
  assign bus.odd        = odd_q;
  assign bus.sym_strobe = strobe_q;
  assign bus.underflow  = underflow_q;

  qpsk_symbol_timer #(
    .SYM_CYCLES (SYM_CYCLES)
  ) u_timer (
    .clk      (clk),
    .reset    (reset),
    .en       (tmr_en),
    .clr      (tmr_clr),
    .idx      (idx),
    .bit_end  (bit_end),
    .word_end (word_end)
  );

  // FSM, pending buffer and registered outputs; underflow lands one cycle after bit3 ends.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      cur         <= '0;
      pend        <= '0;
      pend_v      <= 1'b0;
      uf_pend     <= 1'b0;
      sym_first   <= 1'b1;
      even_q      <= 1'b0;
      odd_q       <= 1'b0;
      strobe_q    <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      even_q      <= 1'b0;
      odd_q       <= 1'b0;
      strobe_q    <= 1'b0;
      underflow_q <= uf_pend;
      uf_pend     <= 1'b0;
      case (state)
        IDLE: begin
          sym_first <= 1'b1;
          if (xfer) begin
            cur   <= in_pair;
            state <= RUN;
          end
        end
        RUN: begin
          if (bus.run_en) begin
            even_q    <= cur.even[idx];
            odd_q     <= cur.odd[idx];
            strobe_q  <= sym_first;
            sym_first <= bit_end;
          end
          if (word_end) begin
            if (pend_v) begin
              cur    <= pend;
              pend_v <= 1'b0;
            end else if (xfer) begin
              cur <= in_pair;
            end else begin
              state   <= IDLE;
              uf_pend <= 1'b1;
            end
          end else if (xfer) begin
            pend   <= in_pair;
            pend_v <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qpsk_symbol_sequencer.sv
// Scoreboard bench: stimulus queues expected symbols/underflows, a monitor checks them.
module tb_qpsk_symbol_sequencer;
  import qpsk_pkg::*;

  localparam int S  = 52;
  localparam int S2 = 2;

  typedef struct {
    int   cyc;
    logic e;
    logic o;
  } exp_t;

  logic clk   = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  qpsk_symbol_sequencer_if ifc ();
  qpsk_symbol_sequencer_if ifc2 ();

  qpsk_symbol_sequencer #(.SYM_CYCLES(S)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  qpsk_symbol_sequencer #(.SYM_CYCLES(S2)) dut2 (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc2.slave)
  );

  exp_t sb_q[$];
  int   uf_q[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;
  logic run_s = 1'b0;
  int   hold_left = 0;
  logic cur_e = 1'b0;
  logic cur_o = 1'b0;
  int   nf = 0;
  bit   have_prev = 1'b0;
  exp_t mx;
  int   mu;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    run_s <= ifc.run_en;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT strobes or flags underflow.
  always @(negedge clk) begin
    if (!reset) begin
      hold_left = 0;
    end else begin
      while (sb_q.size() > 0 && sb_q[0].cyc < cyc) begin
        chk("strobe_missing", 32'd0, 32'd1);
        void'(sb_q.pop_front());
      end
      while (uf_q.size() > 0 && uf_q[0] < cyc) begin
        chk("underflow_missing", 32'd0, 32'd1);
        void'(uf_q.pop_front());
      end
      if (ifc.underflow) begin
        if (uf_q.size() == 0) chk("underflow_unexpected", 32'd1, 32'd0);
        else begin
          mu = uf_q.pop_front();
          chk("underflow_cycle", cyc, mu);
        end
      end
      if (!run_s) begin
        if (hold_left > 0) begin
          chk("pause_even", {31'd0, ifc.even}, 32'd0);
          chk("pause_odd", {31'd0, ifc.odd}, 32'd0);
          chk("pause_strobe", {31'd0, ifc.sym_strobe}, 32'd0);
        end
      end else if (ifc.sym_strobe) begin
        chk("hold_len", hold_left, 32'd0);
        if (sb_q.size() == 0) chk("strobe_unexpected", 32'd1, 32'd0);
        else begin
          mx = sb_q.pop_front();
          chk("strobe_cycle", cyc, mx.cyc);
          chk("sym_even", {31'd0, ifc.even}, {31'd0, mx.e});
          chk("sym_odd", {31'd0, ifc.odd}, {31'd0, mx.o});
          cur_e = mx.e;
          cur_o = mx.o;
        end
        hold_left = S - 1;
      end else if (hold_left > 0) begin
        chk("hold_even", {31'd0, ifc.even}, {31'd0, cur_e});
        chk("hold_odd", {31'd0, ifc.odd}, {31'd0, cur_o});
        hold_left--;
      end
    end
  end

  // Called at a negedge; returns the edge number at which the transfer happens.
  task automatic send(input logic [3:0] e, input logic [3:0] o, output int k);
    int guard;
    guard = 0;
    ifc.in_even  = e;
    ifc.in_odd   = o;
    ifc.in_valid = 1'b1;
    while (!ifc.in_ready && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 1000) begin
      chk("ready_timeout", 32'd0, 32'd1);
      k = -1;
    end else begin
      k = cyc + 1;
    end
    @(negedge clk);
    ifc.in_valid = 1'b0;
  endtask

  task automatic push_word(input int k, input logic [3:0] e, input logic [3:0] o);
    int start;
    start = (have_prev && nf > k + 1) ? nf : k + 1;
    for (int i = 0; i < 4; i++) sb_q.push_back('{start + i * S, e[i], o[i]});
    nf = start + 4 * S;
    have_prev = 1'b1;
  endtask

  task automatic close_stream();
    if (have_prev) uf_q.push_back(nf);
    have_prev = 1'b0;
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, k2, s, p;
    logic [3:0] e2, o2;
    ifc.run_en = 1'b0;  ifc.in_even = '0;  ifc.in_odd = '0;  ifc.in_valid = 1'b0;
    ifc2.run_en = 1'b0; ifc2.in_even = '0; ifc2.in_odd = '0; ifc2.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_even", {31'd0, ifc.even}, 32'd0);
    chk("rst_odd", {31'd0, ifc.odd}, 32'd0);
    chk("rst_strobe", {31'd0, ifc.sym_strobe}, 32'd0);
    chk("rst_underflow", {31'd0, ifc.underflow}, 32'd0);
    chk("rst_busy", {31'd0, ifc.busy}, 32'd0);
    reset = 1'b1;
    @(negedge clk);
    chk("rst_ready", {31'd0, ifc.in_ready}, 32'd1);
    ifc.run_en  = 1'b1;
    ifc2.run_en = 1'b1;
    @(negedge clk);

    // Single word: 0/0, 1/1, 0/1, 1/0 then underflow at k+209.
    send(4'b1010, 4'b0110, k);
    push_word(k, 4'b1010, 4'b0110);
    close_stream();
    wait_until(k + 1);
    chk("t1_first_strobe", {31'd0, ifc.sym_strobe}, 32'd1);
    chk("t1_busy", {31'd0, ifc.busy}, 32'd1);
    wait_until(k + 212);
    chk("t1_idle_busy", {31'd0, ifc.busy}, 32'd0);

    // Back-to-back three words.
    send(4'b0011, 4'b0101, k);
    push_word(k, 4'b0011, 4'b0101);
    send(4'b1100, 4'b1001, k);
    push_word(k, 4'b1100, 4'b1001);
    chk("t2_ready_low", {31'd0, ifc.in_ready}, 32'd0);
    send(4'b0110, 4'b1110, k);
    push_word(k, 4'b0110, 4'b1110);
    close_stream();
    wait_until(nf + 3);

    // Bypass on the word-end edge.
    send(4'b1001, 4'b0111, k);
    push_word(k, 4'b1001, 4'b0111);
    wait_until(k + 4 * S - 1);
    send(4'b0101, 4'b1010, k2);
    chk("t3_bypass_edge", k2, k + 4 * S);
    push_word(k2, 4'b0101, 4'b1010);
    close_stream();
    wait_until(nf + 3);

    // Pause 20 cycles at cnt=30 of bit1; word stretches to 228 cycles.
    send(4'b1100, 4'b0011, k);
    s = k + 1;
    sb_q.push_back('{s,              1'b0, 1'b1});
    sb_q.push_back('{s + S,          1'b0, 1'b1});
    sb_q.push_back('{s + 2 * S + 20, 1'b1, 1'b0});
    sb_q.push_back('{s + 3 * S + 20, 1'b1, 1'b0});
    uf_q.push_back(s + 228);
    p = s + S + 30;
    wait_until(p - 1);
    ifc.run_en = 1'b0;
    wait_until(p + 10);
    chk("t4_paused_busy", {31'd0, ifc.busy}, 32'd1);
    wait_until(p + 19);
    ifc.run_en = 1'b1;
    wait_until(s + 231);

    // Reset mid-word with pend full.
    send(4'b1111, 4'b1111, k);
    push_word(k, 4'b1111, 4'b1111);
    send(4'b0110, 4'b0110, k2);
    push_word(k2, 4'b0110, 4'b0110);
    chk("t5_pend_full", {31'd0, ifc.in_ready}, 32'd0);
    wait_until(k + 80);
    chk("t5_pre_even", {31'd0, ifc.even}, 32'd1);
    #2 reset = 1'b0;
    #1;
    chk("t5_rst_even", {31'd0, ifc.even}, 32'd0);
    chk("t5_rst_odd", {31'd0, ifc.odd}, 32'd0);
    chk("t5_rst_busy", {31'd0, ifc.busy}, 32'd0);
    sb_q.delete();
    uf_q.delete();
    have_prev = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("t5_ready", {31'd0, ifc.in_ready}, 32'd1);
    chk("t5_busy", {31'd0, ifc.busy}, 32'd0);
    repeat (500) @(negedge clk);

    // SYM_CYCLES=2 build: 4 symbols in 8 cycles, strobe every 2.
    e2 = 4'b0110;
    o2 = 4'b1001;
    chk("t6_ready", {31'd0, ifc2.in_ready}, 32'd1);
    ifc2.in_even  = e2;
    ifc2.in_odd   = o2;
    ifc2.in_valid = 1'b1;
    @(negedge clk);
    ifc2.in_valid = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      chk("t6_even", {31'd0, ifc2.even}, {31'd0, e2[c / 2]});
      chk("t6_odd", {31'd0, ifc2.odd}, {31'd0, o2[c / 2]});
      chk("t6_strobe", {31'd0, ifc2.sym_strobe}, (c % 2 == 0) ? 32'd1 : 32'd0);
    end
    @(negedge clk);
    chk("t6_underflow", {31'd0, ifc2.underflow}, 32'd1);
    chk("t6_even_idle", {31'd0, ifc2.even}, 32'd0);

    @(negedge clk);
    chk("sb_queue_empty", sb_q.size(), 32'd0);
    chk("uf_queue_empty", uf_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
